// File: rtl/core_regfile_read_pkg.sv
// Shared core types for the register file slice: data word, register number, NZCV flags.
// Optional feature macro used by this slice: CORE_REGS_BYPASS_EN.
package core_regfile_read_pkg;

    localparam int WORD_W   = 32;
    localparam int REG_W    = 4;
    localparam int FLAGS_W  = 4;
    localparam int NUM_REGS = 15;

    typedef logic [WORD_W-1:0]  word;
    typedef logic [REG_W-1:0]   reg_num;
    // Bit order is {N, Z, C, V}
    typedef logic [FLAGS_W-1:0] psr_flags;

    localparam reg_num R15 = 4'd15;

endpackage

// File: rtl/core_regfile_scoreboard.sv
// Pending-write scoreboard: one bit per stored register, set on issue, cleared on writeback.
// With CORE_REGS_BYPASS_EN undefined, a same-cycle writeback to a requested register also stalls.
module core_regfile_scoreboard
    import core_regfile_read_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rd_a_req,
    input  logic [REG_W-1:0]   rd_a_num,
    input  logic               rd_b_req,
    input  logic [REG_W-1:0]   rd_b_num,
    input  logic               issue_en,
    input  logic [REG_W-1:0]   issue_rd,
    input  logic               wb_en,
    input  logic [REG_W-1:0]   wb_rd,
    output logic               hazard,
    output logic [NUM_REGS-1:0] pending
);

    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;
    logic [15:0]         w_pending16;
    logic                w_hz_a;
    logic                w_hz_b;
    logic                w_wb_a;
    logic                w_wb_b;

    // Shifting a one into bit 15 falls off the truncated mask, so R15 never becomes pending.
    assign w_set_mask  = issue_en ? NUM_REGS'(16'd1 << issue_rd) : '0;
    assign w_clr_mask  = wb_en    ? NUM_REGS'(16'd1 << wb_rd)    : '0;
    assign w_pending16 = {1'b0, r_pending};

    // Clear first, then set, so an issue to the same register wins over its writeback.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
        end
    end

    assign w_hz_a = rd_a_req && w_pending16[rd_a_num];
    assign w_hz_b = rd_b_req && w_pending16[rd_b_num];

`ifdef CORE_REGS_BYPASS_EN
    assign w_wb_a = 1'b0;
    assign w_wb_b = 1'b0;
`else
    assign w_wb_a = rd_a_req && wb_en && (wb_rd != R15) && (rd_a_num == wb_rd);
    assign w_wb_b = rd_b_req && wb_en && (wb_rd != R15) && (rd_b_num == wb_rd);
`endif

    assign hazard  = w_hz_a || w_hz_b || w_wb_a || w_wb_b;
    assign pending = r_pending;

endmodule

// File: rtl/core_regfile_read.sv
// Architectural register file R0-R14 with two registered read ports, NZCV flags and R15-write branch.
// CORE_REGS_BYPASS_EN forwards a same-edge writeback to a matching read request.
module core_regfile_read
    import core_regfile_read_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rd_a_req,
    input  logic                rd_b_req,
    input  logic [REG_W-1:0]    rd_a_num,
    input  logic [REG_W-1:0]    rd_b_num,
    input  logic [WORD_W-1:0]   pc_visible,
    output logic [WORD_W-1:0]   rd_a,
    output logic [WORD_W-1:0]   rd_b,
    output logic                hazard,
    input  logic                issue_en,
    input  logic [REG_W-1:0]    issue_rd,
    input  logic                wb_en,
    input  logic [REG_W-1:0]    wb_rd,
    input  logic [WORD_W-1:0]   wb_value,
    input  logic                wb_update_flags,
    input  logic [FLAGS_W-1:0]  wb_flags,
    output logic [FLAGS_W-1:0]  flags,
    output logic                branch,
    output logic [WORD_W-1:0]   branch_target
);

    // Read handshake: a request is always sampled at the edge; when hazard is high in that
    // cycle the returned data is stale and issue must re-request on the following cycle.

    word                 r_regs [NUM_REGS];
    word                 r_rd_a;
    word                 r_rd_b;
    psr_flags            r_flags;
    logic                r_branch;
    word                 r_branch_target;
    word                 w_rd_a_data;
    word                 w_rd_b_data;
    logic                w_wb_reg;
    logic [NUM_REGS-1:0] w_pending;

    assign w_wb_reg = wb_en && (wb_rd != R15);

    always_comb begin
        w_rd_a_data = (rd_a_num == R15) ? pc_visible : r_regs[rd_a_num];
        w_rd_b_data = (rd_b_num == R15) ? pc_visible : r_regs[rd_b_num];
`ifdef CORE_REGS_BYPASS_EN
        if (w_wb_reg && (rd_a_num == wb_rd)) w_rd_a_data = wb_value;
        if (w_wb_reg && (rd_b_num == wb_rd)) w_rd_b_data = wb_value;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_rd_a          <= '0;
            r_rd_b          <= '0;
            r_flags         <= '0;
            r_branch        <= 1'b0;
            r_branch_target <= '0;
        end else begin
            if (w_wb_reg) begin
                r_regs[wb_rd] <= wb_value;
            end
            if (rd_a_req) r_rd_a <= w_rd_a_data;
            if (rd_b_req) r_rd_b <= w_rd_b_data;
            if (wb_update_flags) r_flags <= wb_flags;
            // R15 is not stored; a write to it becomes a one-cycle branch request.
            r_branch <= wb_en && (wb_rd == R15);
            if (wb_en && (wb_rd == R15)) begin
                r_branch_target <= wb_value;
            end
        end
    end

    core_regfile_scoreboard u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_a_req (rd_a_req),
        .rd_a_num (rd_a_num),
        .rd_b_req (rd_b_req),
        .rd_b_num (rd_b_num),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .hazard   (hazard),
        .pending  (w_pending)
    );

    assign rd_a          = r_rd_a;
    assign rd_b          = r_rd_b;
    assign flags         = r_flags;
    assign branch        = r_branch;
    assign branch_target = r_branch_target;

endmodule

// File: tb/tb_core_regfile_read.sv
// Self-checking bench for core_regfile_read; read results go through an expected-value queue.
module tb_core_regfile_read;

    logic        clk;
    logic        rst_n;
    logic        rd_a_req, rd_b_req;
    logic [3:0]  rd_a_num, rd_b_num;
    logic [31:0] pc_visible;
    logic [31:0] rd_a, rd_b;
    logic        hazard;
    logic        issue_en;
    logic [3:0]  issue_rd;
    logic        wb_en;
    logic [3:0]  wb_rd;
    logic [31:0] wb_value;
    logic        wb_update_flags;
    logic [3:0]  wb_flags;
    logic [3:0]  flags;
    logic        branch;
    logic [31:0] branch_target;

    logic [31:0] exp_q[$];
    logic [31:0] m_regs [15];
    logic [31:0] exp_v;
    int          total = 0;
    int          bad   = 0;

    core_regfile_read dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rd_a_req        (rd_a_req),
        .rd_b_req        (rd_b_req),
        .rd_a_num        (rd_a_num),
        .rd_b_num        (rd_b_num),
        .pc_visible      (pc_visible),
        .rd_a            (rd_a),
        .rd_b            (rd_b),
        .hazard          (hazard),
        .issue_en        (issue_en),
        .issue_rd        (issue_rd),
        .wb_en           (wb_en),
        .wb_rd           (wb_rd),
        .wb_value        (wb_value),
        .wb_update_flags (wb_update_flags),
        .wb_flags        (wb_flags),
        .flags           (flags),
        .branch          (branch),
        .branch_target   (branch_target)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic idle();
        rd_a_req = 0; rd_b_req = 0; rd_a_num = 0; rd_b_num = 0;
        issue_en = 0; issue_rd = 0; wb_en = 0; wb_rd = 0; wb_value = 0;
        wb_update_flags = 0; wb_flags = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wb(input logic [3:0] r, input logic [31:0] v);
        wb_en = 1; wb_rd = r; wb_value = v;
        if (r != 4'd15) m_regs[r] = v;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle();
        tick(); tick();
        if (rd_a !== 32'h0) begin bad++; $display("FAIL reset_rd_a got=%h exp=0", rd_a); end
        total++;
        if (rd_b !== 32'h0) begin bad++; $display("FAIL reset_rd_b got=%h exp=0", rd_b); end
        total++;
        if (flags !== 4'h0) begin bad++; $display("FAIL reset_flags got=%h exp=0", flags); end
        total++;
        if (branch !== 1'b0 || branch_target !== 32'h0) begin
            bad++; $display("FAIL reset_branch got=%b/%h exp=0/0", branch, branch_target);
        end
        total++;
        rst_n = 1;
        for (int i = 0; i < 15; i++) m_regs[i] = 32'h0;
        pc_visible = 32'h108;
        for (int i = 0; i < 16; i++) begin
            rd_a_req = 1; rd_a_num = 4'(i);
            rd_b_req = 1; rd_b_num = 4'(15 - i);
            exp_q.push_back((i == 15) ? 32'h108 : 32'h0);
            exp_q.push_back((i == 0)  ? 32'h108 : 32'h0);
            #1;
            if (hazard !== 1'b0) begin bad++; $display("FAIL reset_hazard r%0d got=%b exp=0", i, hazard); end
            total++;
            tick();
            exp_v = exp_q.pop_front();
            if (rd_a !== exp_v) begin bad++; $display("FAIL reset_read_a r%0d got=%h exp=%h", i, rd_a, exp_v); end
            total++;
            exp_v = exp_q.pop_front();
            if (rd_b !== exp_v) begin bad++; $display("FAIL reset_read_b r%0d got=%h exp=%h", 15 - i, rd_b, exp_v); end
            total++;
        end
        idle();
    endtask

    task automatic test_write_read();
        logic [3:0] r;
        drive_wb(4'd3, 32'hDEADBEEF);
        tick();
        idle();
        rd_a_req = 1; rd_a_num = 4'd3;
        exp_q.push_back(32'hDEADBEEF);
        tick();
        idle();
        exp_v = exp_q.pop_front();
        if (rd_a !== exp_v) begin bad++; $display("FAIL wr_rd_r3 got=%h exp=%h", rd_a, exp_v); end
        total++;
        // held value when not requested
        tick();
        if (rd_a !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rd_hold got=%h exp=deadbeef", rd_a); end
        total++;
        for (int k = 0; k < 10; k++) begin
            r = 4'($urandom_range(0, 14));
            drive_wb(r, $urandom);
            tick();
            idle();
        end
        for (int k = 0; k < 15; k++) begin
            rd_a_req = 1; rd_a_num = 4'(k);
            rd_b_req = 1; rd_b_num = 4'(14 - k);
            exp_q.push_back(m_regs[k]);
            exp_q.push_back(m_regs[14 - k]);
            tick();
            exp_v = exp_q.pop_front();
            if (rd_a !== exp_v) begin bad++; $display("FAIL rand_read_a r%0d got=%h exp=%h", k, rd_a, exp_v); end
            total++;
            exp_v = exp_q.pop_front();
            if (rd_b !== exp_v) begin bad++; $display("FAIL rand_read_b r%0d got=%h exp=%h", 14 - k, rd_b, exp_v); end
            total++;
        end
        idle();
    endtask

    task automatic test_same_edge();
        logic exp_h;
        drive_wb(4'd5, 32'h11);
        tick();
        idle();
        drive_wb(4'd5, 32'h55);
        rd_a_req = 1; rd_a_num = 4'd5;
`ifdef CORE_REGS_BYPASS_EN
        exp_q.push_back(32'h55);
        exp_h = 1'b0;
`else
        exp_q.push_back(32'h11);
        exp_h = 1'b1;
`endif
        #1;
        if (hazard !== exp_h) begin bad++; $display("FAIL same_edge_hazard got=%b exp=%b", hazard, exp_h); end
        total++;
        tick();
        idle();
        exp_v = exp_q.pop_front();
        if (rd_a !== exp_v) begin bad++; $display("FAIL same_edge_data got=%h exp=%h", rd_a, exp_v); end
        total++;
        rd_a_req = 1; rd_a_num = 4'd5;
        exp_q.push_back(32'h55);
        tick();
        idle();
        exp_v = exp_q.pop_front();
        if (rd_a !== exp_v) begin bad++; $display("FAIL same_edge_after got=%h exp=%h", rd_a, exp_v); end
        total++;
    endtask

    task automatic test_scoreboard();
        issue_en = 1; issue_rd = 4'd7;
        tick();
        idle();
        rd_a_req = 1; rd_a_num = 4'd7;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (hazard !== 1'b1) begin bad++; $display("FAIL sb_pending_a c%0d got=%b exp=1", k, hazard); end
            total++;
            tick();
        end
        rd_a_req = 0; rd_b_req = 1; rd_b_num = 4'd7;
        #1;
        if (hazard !== 1'b1) begin bad++; $display("FAIL sb_pending_b got=%b exp=1", hazard); end
        total++;
        rd_b_req = 0; rd_a_req = 1;
        drive_wb(4'd7, 32'h7777);
        #1;
        if (hazard !== 1'b1) begin bad++; $display("FAIL sb_wb_cycle got=%b exp=1", hazard); end
        total++;
        tick();
        wb_en = 0;
        #1;
        if (hazard !== 1'b0) begin bad++; $display("FAIL sb_cleared got=%b exp=0", hazard); end
        total++;
        idle();
        // set wins over clear on the same register and edge
        issue_en = 1; issue_rd = 4'd9;
        drive_wb(4'd9, 32'h99);
        tick();
        idle();
        rd_a_req = 1; rd_a_num = 4'd9;
        exp_q.push_back(32'h99);
        #1;
        if (hazard !== 1'b1) begin bad++; $display("FAIL sb_set_wins got=%b exp=1", hazard); end
        total++;
        tick();
        exp_v = exp_q.pop_front();
        if (rd_a !== exp_v) begin bad++; $display("FAIL sb_set_wins_data got=%h exp=%h", rd_a, exp_v); end
        total++;
        rd_a_req = 0;
        drive_wb(4'd9, 32'h9A);
        tick();
        idle();
        rd_a_req = 1; rd_a_num = 4'd9;
        #1;
        if (hazard !== 1'b0) begin bad++; $display("FAIL sb_r9_cleared got=%b exp=0", hazard); end
        total++;
        idle();
        // R15 never pending
        issue_en = 1; issue_rd = 4'd15;
        tick();
        idle();
        rd_a_req = 1; rd_a_num = 4'd15;
        #1;
        if (hazard !== 1'b0) begin bad++; $display("FAIL sb_r15 got=%b exp=0", hazard); end
        total++;
        idle();
    endtask

    task automatic test_branch();
        drive_wb(4'd15, 32'h8000);
        tick();
        idle();
        if (branch !== 1'b1 || branch_target !== 32'h8000) begin
            bad++; $display("FAIL branch_pulse got=%b/%h exp=1/00008000", branch, branch_target);
        end
        total++;
        tick();
        if (branch !== 1'b0 || branch_target !== 32'h8000) begin
            bad++; $display("FAIL branch_end got=%b/%h exp=0/00008000", branch, branch_target);
        end
        total++;
        for (int k = 0; k < 15; k++) begin
            rd_a_req = 1; rd_a_num = 4'(k);
            exp_q.push_back(m_regs[k]);
            tick();
            exp_v = exp_q.pop_front();
            if (rd_a !== exp_v) begin bad++; $display("FAIL branch_regs r%0d got=%h exp=%h", k, rd_a, exp_v); end
            total++;
        end
        idle();
    endtask

    task automatic test_flags_reset();
        wb_update_flags = 1; wb_flags = 4'b1010;
        tick();
        idle();
        if (flags !== 4'b1010) begin bad++; $display("FAIL flags_update got=%b exp=1010", flags); end
        total++;
        // leave a pending bit and a live branch behind to prove reset discards them
        issue_en = 1; issue_rd = 4'd4;
        drive_wb(4'd15, 32'hABCD);
        tick();
        idle();
        rst_n = 0;
        drive_wb(4'd2, 32'hFFFF);
        wb_update_flags = 1; wb_flags = 4'b0101;
        tick();
        rst_n = 1;
        idle();
        for (int i = 0; i < 15; i++) m_regs[i] = 32'h0;
        if (rd_a !== 0 || rd_b !== 0 || flags !== 0 || branch !== 0 || branch_target !== 0) begin
            bad++;
            $display("FAIL post_reset got=%h/%h/%b/%b/%h exp=all zero", rd_a, rd_b, flags, branch, branch_target);
        end
        total++;
        rd_a_req = 1; rd_a_num = 4'd4;
        rd_b_req = 1; rd_b_num = 4'd3;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        #1;
        if (hazard !== 1'b0) begin bad++; $display("FAIL post_reset_hazard got=%b exp=0", hazard); end
        total++;
        tick();
        idle();
        exp_v = exp_q.pop_front();
        if (rd_a !== exp_v) begin bad++; $display("FAIL post_reset_r4 got=%h exp=%h", rd_a, exp_v); end
        total++;
        exp_v = exp_q.pop_front();
        if (rd_b !== exp_v) begin bad++; $display("FAIL post_reset_r3 got=%h exp=%h", rd_b, exp_v); end
        total++;
    endtask

    initial begin
        rst_n = 0;
        pc_visible = 32'h108;
        idle();
        test_reset();
        test_write_read();
        test_same_edge();
        test_scoreboard();
        test_branch();
        test_flags_reset();
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL queue_drain left=%0d exp=0", exp_q.size());
        end
        total++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
